// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard controller: load-use stall, branch flush, data-memory wait/timeout.
// Zero-latency combinational controls from registered state; a stalled memory access freezes the whole pipe.
module pipe_hazard_ctrl #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rd_i,
  input  logic [4:0]  ifid_rs1_i,
  input  logic [4:0]  ifid_rs2_i,
  input  logic        ifid_uses_rs2_i,
  input  logic        branch_taken_i,
  input  logic        exmem_memreq_i,
  input  logic        dmem_ready_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic        pipe_hold_o,
  output logic        dmem_req_o,
  output logic [1:0]  state_o,
  output logic        err_o,
  output logic [15:0] stall_cnt_o
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MEMWAIT = 2'd1;
  localparam logic [1:0] ST_HALT    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        load_use;

  assign load_use = idex_memread_i && (idex_rd_i != 5'd0) &&
                    ((idex_rd_i == ifid_rs1_i) ||
                     (ifid_uses_rs2_i && (idex_rd_i == ifid_rs2_i)));

  always_comb begin
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    pipe_hold_o  = 1'b0;
    dmem_req_o   = exmem_memreq_i;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;

    case (state_q)
      ST_RUN: begin
        // Priority: memory stall, then branch redirect, then load-use bubble.
        if (exmem_memreq_i && !dmem_ready_i) begin
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          pipe_hold_o  = 1'b1;
          state_d      = ST_MEMWAIT;
          wait_cnt_d   = 8'd1;
        end else if (branch_taken_i) begin
          ifid_flush_o = 1'b1;
          idex_flush_o = 1'b1;
        end else if (load_use) begin
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          idex_flush_o = 1'b1;
        end
      end

      ST_MEMWAIT: begin
        // Ready wins over timeout; branch and load-use are ignored while waiting.
        if (dmem_ready_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          pipe_hold_o  = 1'b1;
          if (wait_cnt_q == MEM_TIMEOUT) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end

      ST_HALT: begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        pipe_hold_o  = 1'b1;
        dmem_req_o   = 1'b0;
      end

      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state_o     = state_q;
  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboarded directed test of pipe_hazard_ctrl with MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        idex_memread_i = 1'b0;
  logic [4:0]  idex_rd_i = 5'd0;
  logic [4:0]  ifid_rs1_i = 5'd0;
  logic [4:0]  ifid_rs2_i = 5'd0;
  logic        ifid_uses_rs2_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic        exmem_memreq_i = 1'b0;
  logic        dmem_ready_i = 1'b0;
  logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o;
  logic        pipe_hold_o, dmem_req_o, err_o;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(8'd4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
    .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i),
    .ifid_uses_rs2_i(ifid_uses_rs2_i), .branch_taken_i(branch_taken_i),
    .exmem_memreq_i(exmem_memreq_i), .dmem_ready_i(dmem_ready_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o),
    .pipe_hold_o(pipe_hold_o), .dmem_req_o(dmem_req_o),
    .state_o(state_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );

  // Expected word: {pcw, ifw, ifid_flush, idex_flush, hold, dreq, state[1:0], err, stall_cnt[15:0]}
  typedef logic [24:0] exp_t;
  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  localparam logic [5:0] C_IDLE = 6'b110000;
  localparam logic [5:0] C_MEMH = 6'b110001;
  localparam logic [5:0] C_BR   = 6'b111100;
  localparam logic [5:0] C_LU   = 6'b000100;
  localparam logic [5:0] C_FRZ  = 6'b000011;
  localparam logic [5:0] C_HALT = 6'b000010;

  task automatic vec(input string nm, input logic rst, input logic memread,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic uses2, input logic br, input logic memreq, input logic rdy,
                     input logic [5:0] ctl, input logic [1:0] st, input logic err,
                     input logic [15:0] scnt);
    @(posedge clk_i);
    #1;
    rst_i           = rst;
    idex_memread_i  = memread;
    idex_rd_i       = rd;
    ifid_rs1_i      = rs1;
    ifid_rs2_i      = rs2;
    ifid_uses_rs2_i = uses2;
    branch_taken_i  = br;
    exmem_memreq_i  = memreq;
    dmem_ready_i    = rdy;
    exp_q.push_back({ctl, st, err, scnt});
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    exp_t  e;
    exp_t  act;
    string nm;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, pipe_hold_o,
               dmem_req_o, state_o, err_o, stall_cnt_o};
        n_cmp++;
        if (act !== e) begin
          n_err++;
          $display("FAIL %s: got ctl=%b st=%0d err=%b cnt=%h, expected ctl=%b st=%0d err=%b cnt=%h",
                   nm, act[24:19], act[18:17], act[16], act[15:0],
                   e[24:19], e[18:17], e[16], e[15:0]);
        end
      end
    end
  end

  initial begin : stim
    //   name           rst mr rd  rs1 rs2 u2 br mq rdy  ctl     st err cnt
    vec("reset",        1, 0, 0,  0,  0,  0, 0, 0, 0,  C_IDLE, 0, 0, 16'd0);
    vec("idle",         0, 0, 0,  0,  0,  0, 0, 0, 0,  C_IDLE, 0, 0, 16'd0);
    vec("load_use",     0, 1, 5,  5,  0,  0, 0, 0, 0,  C_LU,   0, 0, 16'd0);
    vec("after_lu",     0, 0, 0,  0,  0,  0, 0, 0, 0,  C_IDLE, 0, 0, 16'd1);
    vec("rd_zero",      0, 1, 0,  0,  0,  0, 0, 0, 0,  C_IDLE, 0, 0, 16'd1);
    vec("rd_zero_nxt",  0, 0, 0,  0,  0,  0, 0, 0, 0,  C_IDLE, 0, 0, 16'd1);
    vec("lu_rs2",       0, 1, 7,  3,  7,  1, 0, 0, 0,  C_LU,   0, 0, 16'd1);
    vec("rs2_unused",   0, 1, 7,  3,  7,  0, 0, 0, 0,  C_IDLE, 0, 0, 16'd2);
    vec("no_load",      0, 0, 5,  5,  0,  0, 0, 0, 0,  C_IDLE, 0, 0, 16'd2);
    vec("br_plus_lu",   0, 1, 5,  5,  0,  0, 1, 0, 0,  C_BR,   0, 0, 16'd2);
    vec("br_only",      0, 0, 0,  0,  0,  0, 1, 0, 0,  C_BR,   0, 0, 16'd2);
    vec("mem_hit",      0, 0, 0,  0,  0,  0, 0, 1, 1,  C_MEMH, 0, 0, 16'd2);
    vec("miss_1",       0, 1, 5,  5,  0,  0, 1, 1, 0,  C_FRZ,  0, 0, 16'd2);
    vec("miss_2",       0, 0, 0,  0,  0,  0, 1, 1, 0,  C_FRZ,  1, 0, 16'd3);
    vec("miss_3",       0, 0, 0,  0,  0,  0, 0, 1, 0,  C_FRZ,  1, 0, 16'd4);
    vec("miss_done",    0, 1, 5,  5,  0,  0, 1, 1, 1,  C_MEMH, 1, 0, 16'd5);
    vec("post_mem",     0, 0, 0,  0,  0,  0, 0, 0, 0,  C_IDLE, 0, 0, 16'd5);
    vec("to_run",       0, 0, 0,  0,  0,  0, 0, 1, 0,  C_FRZ,  0, 0, 16'd5);
    vec("to_w1",        0, 0, 0,  0,  0,  0, 0, 1, 0,  C_FRZ,  1, 0, 16'd6);
    vec("to_w2",        0, 0, 0,  0,  0,  0, 0, 1, 0,  C_FRZ,  1, 0, 16'd7);
    vec("to_w3",        0, 0, 0,  0,  0,  0, 0, 1, 0,  C_FRZ,  1, 0, 16'd8);
    vec("to_w4",        0, 0, 0,  0,  0,  0, 0, 1, 0,  C_FRZ,  1, 0, 16'd9);
    vec("halt",         0, 0, 0,  0,  0,  0, 0, 1, 1,  C_HALT, 2, 1, 16'd10);
    vec("halt_br",      0, 0, 0,  0,  0,  0, 1, 0, 0,  C_HALT, 2, 1, 16'd11);
    vec("halt_rst",     1, 0, 0,  0,  0,  0, 0, 1, 1,  C_MEMH, 0, 0, 16'd0);
    vec("post_rst",     0, 0, 0,  0,  0,  0, 0, 1, 1,  C_MEMH, 0, 0, 16'd0);
    vec("mw_enter",     0, 0, 0,  0,  0,  0, 0, 1, 0,  C_FRZ,  0, 0, 16'd0);
    vec("mw_rst",       1, 0, 0,  0,  0,  0, 0, 1, 0,  C_FRZ,  0, 0, 16'd0);
    vec("mw_rst_rel",   0, 0, 0,  0,  0,  0, 0, 0, 0,  C_IDLE, 0, 0, 16'd0);
    vec("rp_run",       0, 0, 0,  0,  0,  0, 0, 1, 0,  C_FRZ,  0, 0, 16'd0);
    vec("rp_w1",        0, 0, 0,  0,  0,  0, 0, 1, 0,  C_FRZ,  1, 0, 16'd1);
    vec("rp_w2",        0, 0, 0,  0,  0,  0, 0, 1, 0,  C_FRZ,  1, 0, 16'd2);
    vec("rp_w3",        0, 0, 0,  0,  0,  0, 0, 1, 0,  C_FRZ,  1, 0, 16'd3);
    vec("rp_ready_win", 0, 0, 0,  0,  0,  0, 0, 1, 1,  C_MEMH, 1, 0, 16'd4);
    vec("rp_idle",      0, 0, 0,  0,  0,  0, 0, 0, 0,  C_IDLE, 0, 0, 16'd4);

    // Hold a load-use hazard long enough to overflow the stall counter.
    @(posedge clk_i);
    #1;
    idex_memread_i = 1'b1;
    idex_rd_i      = 5'd9;
    ifid_rs1_i     = 5'd9;
    repeat (70000) @(posedge clk_i);

    vec("sat_hold",     0, 1, 9,  9,  0,  0, 0, 0, 0,  C_LU,   0, 0, 16'hFFFF);
    vec("sat_idle",     0, 0, 0,  0,  0,  0, 0, 0, 0,  C_IDLE, 0, 0, 16'hFFFF);

    repeat (3) @(posedge clk_i);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
